usb_data_fifo: RTL
==================

# usb_data_fifo

Parametrised byte-granular endpoint data FIFO, next generation of the separate fixed-size TX and RX data buffers between the AHB-lite slave and the USB transceivers. One instance serves either direction, chosen by a parameter. The bus side moves 1/2/4/8 bytes per access by size code and the USB side moves one byte per access. RX mode supports packet-level commit/rollback so a corrupted packet never becomes visible to the bus.

## Interface
- DEPTH, 64: capacity in bytes; power of two, 8..1024
- BUS_W, 32: bus data width in bits; 16, 32 or 64
- DIR, DIR_TX: DIR_TX = bus writes, USB reads; DIR_RX = USB writes, bus reads
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- clear  in  1  synchronous flush of all contents and pointers
- bus_push  in  1  bus write request (honoured in DIR_TX only)
- bus_pop  in  1  bus read request (honoured in DIR_RX only)
- bus_size  in  2  0 byte, 1 half, 2 word, 3 dword (3 legal only when BUS_W=64)
- bus_wdata  in  BUS_W  write data, little-endian, byte 0 enters first
- bus_rdata  out  BUS_W  head bytes, byte 0 = oldest
- usb_push  in  1  USB byte write (DIR_RX only)
- usb_wdata  in  8  USB write byte
- usb_pop  in  1  USB byte read (DIR_TX only)
- usb_rdata  out  8  oldest byte
- commit  in  1  publish all bytes written since the last commit (DIR_RX)
- rollback  in  1  discard all bytes written since the last commit (DIR_RX)
- occupancy  out  $clog2(DEPTH)+1  committed readable bytes
- full  out  1  no free space (committed plus uncommitted bytes = DEPTH)
- empty  out  1  occupancy == 0
- overflow  out  1  one-cycle pulse: rejected push
- underflow  out  1  one-cycle pulse: rejected pop

## Operation
- Pointers rd_ptr, cm_ptr, wr_ptr, each $clog2(DEPTH)+1 bits, wrap modulo 2*DEPTH. occupancy = cm_ptr - rd_ptr. free = DEPTH - (wr_ptr - rd_ptr).
- Write of N bytes (N from size, or 1 for USB): accepted only if free >= N, checked at cycle start. A rejected write changes nothing and pulses overflow.
- Pop of N bytes: accepted only if occupancy >= N, checked at cycle start. A rejected pop changes nothing and pulses underflow.
- In DIR_TX every write auto-commits (cm_ptr follows wr_ptr); commit and rollback are ignored.
- Requests belonging to the other direction are ignored silently.
- bus_rdata: combinational view of the oldest BUS_W/8 bytes; bytes at positions >= occupancy read as 0. usb_rdata is the oldest byte, or 0 when empty.
- Priority within a cycle: rst > clear > rollback > commit > push/pop.
- Push and pop in the same cycle are both allowed, each checked against the state at cycle start.
- Commit in the same cycle as an accepted usb_push includes that byte.
- Rollback in the same cycle as usb_push discards the byte, with no overflow pulse.
- Commit together with rollback: rollback wins.
- Pop never touches uncommitted bytes.

## Timing
- Reset/clear: all pointers 0; occupancy 0, empty 1, full 0, overflow 0, underflow 0, bus_rdata 0, usb_rdata 0 on the following cycle.
- Latency: a byte pushed (DIR_TX) or committed (DIR_RX) at edge k is visible on the rdata ports and in occupancy after edge k.
- A pop at edge k shows the next bytes after edge k.
- No back-pressure handshake; requesters must consult full/occupancy, or observe the overflow/underflow pulses.
- Wrap-around is seamless: a multi-byte access spanning the DEPTH boundary splits across address DEPTH-1 and 0 with no penalty.

## Configuration
- USB_FIFO_ROLLBACK_EN defined: commit and rollback behave as above in DIR_RX.
- Not defined: cm_ptr tracks wr_ptr in both directions; commit and rollback are ignored; USB writes are visible one cycle after the push.

## Structure
- Package usb_fifo_pkg holds:
  - typedef enum size_t {SZ_BYTE, SZ_HALF, SZ_WORD, SZ_DWORD}
  - typedef enum dir_t {DIR_TX, DIR_RX}
  - function size_bytes(size_t) returning 1/2/4/8
- Sub-module usb_fifo_mem: DEPTH x 8 storage with a registered multi-byte write port (byte enables, wrapped addresses) and a combinational multi-byte read port. Pointer, commit and status logic stays in usb_data_fifo.

## Test plan
- TX, BUS_W=32, DEPTH=64: push word 0xDDCCBBAA, pop 4 USB bytes -> usb_rdata 0xAA, 0xBB, 0xCC, 0xDD; empty=1 afterwards.
- TX: 16 word pushes -> full=1, occupancy=64; a 17th byte push -> overflow pulse, occupancy stays 64.
- RX with macro: push 0x11, 0x22, 0x33, then rollback -> occupancy 0; push 0x44, 0x55 with commit on 0x55 -> next cycle occupancy 2, bus_rdata 0x00005544.
- RX: word pop with occupancy 3 -> underflow pulse and no pointer change; half pop -> occupancy 1.
- Wrap: DEPTH=8, positions advanced to 6, push word 0x04030201 -> bytes 0x01..0x04 pop in order across the boundary.
- Simultaneous: TX at full, push+pop in same cycle -> pop accepted, push rejected with overflow; clear with push -> occupancy 0.

Source files
------------

// File: rtl/usb_fifo_pkg.sv
// usb_fifo_pkg: shared types and helpers for the endpoint data FIFO.
// Access size codes, direction selector and size-to-byte-count conversion.
package usb_fifo_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'd0,
    SZ_HALF  = 2'd1,
    SZ_WORD  = 2'd2,
    SZ_DWORD = 2'd3
  } size_t;

  typedef enum logic {
    DIR_TX = 1'b0,
    DIR_RX = 1'b1
  } dir_t;

  // Number of bytes moved by one bus access of the given size code.
  function automatic logic [3:0] size_bytes(input size_t sz);
    logic [3:0] n;
    case (sz)
      SZ_BYTE:  n = 4'd1;
      SZ_HALF:  n = 4'd2;
      SZ_WORD:  n = 4'd4;
      SZ_DWORD: n = 4'd8;
      default:  n = 4'd1;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/usb_fifo_mem.sv
// usb_fifo_mem: DEPTH x 8 byte storage for the endpoint data FIFO.
// Registered multi-byte write port with byte enables and a combinational
// multi-byte read port; both ports wrap their byte addresses modulo DEPTH.
module usb_fifo_mem
  import usb_fifo_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int NB    = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [NB-1:0]   wbe,
  input  logic [NB*8-1:0] wdata,
  input  logic [AW-1:0]   raddr,
  output logic [NB*8-1:0] rdata
);

  logic [7:0] mem [DEPTH];

  // Byte-lane writes; lane i lands at waddr+i, wrapping past DEPTH-1 to 0.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (wbe[i]) begin
          mem[waddr + AW'(i)] <= wdata[8*i +: 8];
        end
      end
    end
  end

  // Combinational read of NB consecutive bytes starting at raddr.
  always_comb begin
    rdata = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      rdata[8*i +: 8] = mem[raddr + AW'(i)];
    end
  end

endmodule

// File: rtl/usb_data_fifo.sv
// usb_data_fifo: byte-granular endpoint data FIFO between the AHB-lite slave
// and the USB transceiver. DIR selects TX (bus writes, USB reads) or RX (USB
// writes, bus reads). Bus accesses move 1/2/4/8 bytes, USB accesses one byte.
// Optional feature macro USB_FIFO_ROLLBACK_EN: packet commit/rollback in RX.
// Without it the commit pointer tracks the write pointer in both directions.
module usb_data_fifo
  import usb_fifo_pkg::*;
#(
  parameter int   DEPTH = 64,
  parameter int   BUS_W = 32,
  parameter dir_t DIR   = DIR_TX,
  localparam int  PW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             bus_push,
  input  logic             bus_pop,
  input  logic [1:0]       bus_size,
  input  logic [BUS_W-1:0] bus_wdata,
  output logic [BUS_W-1:0] bus_rdata,
  input  logic             usb_push,
  input  logic [7:0]       usb_wdata,
  input  logic             usb_pop,
  output logic [7:0]       usb_rdata,
  input  logic             commit,
  input  logic             rollback,
  output logic [PW-1:0]    occupancy,
  output logic             full,
  output logic             empty,
  output logic             overflow,
  output logic             underflow
);

  localparam int            AW      = PW - 1;
  localparam int            NB      = BUS_W / 8;
  localparam logic [3:0]    NB_L    = 4'(NB);
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

`ifdef USB_FIFO_ROLLBACK_EN
  localparam bit RB_EN = (DIR == DIR_RX);
`else
  localparam bit RB_EN = 1'b0;
  logic unused_pkt_ctl;
  assign unused_pkt_ctl = commit ^ rollback;
`endif

  logic [PW-1:0]    rd_ptr, cm_ptr, wr_ptr;
  logic [PW-1:0]    rd_nxt, cm_nxt, wr_nxt;
  logic [PW-1:0]    occ, used, free;
  logic [3:0]       bus_n, wr_n, rd_n;
  logic             wr_req, rd_req;
  logic [BUS_W-1:0] wr_data;
  logic [NB-1:0]    wr_be;
  logic             do_rb, do_cm;
  logic             wr_ok, wr_rej, rd_ok, rd_rej;
  logic [BUS_W-1:0] mem_rdata;

  assign occ  = cm_ptr - rd_ptr;
  assign used = wr_ptr - rd_ptr;
  assign free = DEPTH_P - used;

  // Map bus/USB requests onto a generic writer and reader for this direction.
  always_comb begin
    bus_n   = size_bytes(size_t'(bus_size));
    if (bus_n > NB_L) begin
      bus_n = NB_L;
    end
    wr_req  = 1'b0;
    wr_n    = 4'd0;
    wr_data = '0;
    rd_req  = 1'b0;
    rd_n    = 4'd0;
    if (DIR == DIR_TX) begin
      wr_req  = bus_push;
      wr_n    = bus_n;
      wr_data = bus_wdata;
      rd_req  = usb_pop;
      rd_n    = 4'd1;
    end else begin
      wr_req  = usb_push;
      wr_n    = 4'd1;
      wr_data = {{(BUS_W-8){1'b0}}, usb_wdata};
      rd_req  = bus_pop;
      rd_n    = bus_n;
    end
    wr_be = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      wr_be[i] = (4'(i) < wr_n);
    end
  end

  // Acceptance checks against start-of-cycle state and next pointer values.
  // Rollback rewinds the writer to the commit point and swallows any push
  // in the same cycle; commit then publishes whatever the writer reaches.
  always_comb begin
    do_rb  = RB_EN && rollback;
    do_cm  = RB_EN && commit && !rollback;
    wr_ok  = wr_req && (free >= PW'(wr_n)) && !do_rb;
    wr_rej = wr_req && (free <  PW'(wr_n)) && !do_rb;
    rd_ok  = rd_req && (occ >= PW'(rd_n));
    rd_rej = rd_req && (occ <  PW'(rd_n));
    wr_nxt = wr_ptr;
    if (do_rb) begin
      wr_nxt = cm_ptr;
    end else if (wr_ok) begin
      wr_nxt = wr_ptr + PW'(wr_n);
    end
    cm_nxt = cm_ptr;
    if (!RB_EN || do_cm) begin
      cm_nxt = wr_nxt;
    end
    rd_nxt = rd_ok ? (rd_ptr + PW'(rd_n)) : rd_ptr;
  end

  // Pointer and status-pulse registers; reset and clear both flush.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      rd_ptr    <= '0;
      cm_ptr    <= '0;
      wr_ptr    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      rd_ptr    <= rd_nxt;
      cm_ptr    <= cm_nxt;
      wr_ptr    <= wr_nxt;
      overflow  <= wr_rej;
      underflow <= rd_rej;
    end
  end

  usb_fifo_mem #(
    .DEPTH (DEPTH),
    .NB    (NB)
  ) u_mem (
    .clk   (clk),
    .we    (wr_ok && !rst && !clear),
    .waddr (wr_ptr[AW-1:0]),
    .wbe   (wr_be),
    .wdata (wr_data),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (mem_rdata)
  );

  // Head view: only committed bytes are visible, the rest read as zero.
  always_comb begin
    bus_rdata = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      if (PW'(i) < occ) begin
        bus_rdata[8*i +: 8] = mem_rdata[8*i +: 8];
      end
    end
    usb_rdata = (occ == '0) ? 8'h00 : mem_rdata[7:0];
  end

  assign occupancy = occ;
  assign empty     = (occ == '0);
  assign full      = (used == DEPTH_P);

endmodule
